// File: rtl/rs_issue_scheduler.sv
// Age-ordered issue selector for the 16-slot reservation station.
// Define RS_AGE_ISSUE_EN for oldest-first grant; otherwise the lowest-index ready slot wins.
module rs_issue_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        alloc_valid_from_rs,
    input  logic [4:0]  alloc_index_from_rs,
    input  logic [15:0] ready_from_rs,
    input  logic        ex_ready_from_ex,
    input  logic        rollback_flag_from_rob,
    output logic        issue_valid_to_rs,
    output logic [4:0]  issue_index_to_rs,
    output logic [4:0]  pending_count
);

    localparam int          RS_SIZE    = 16;
    localparam logic [4:0]  INVALID_RS = 5'd16;

    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [4:0]         pending_count_q, pending_count_d;

    logic [RS_SIZE-1:0] cand;
    logic               any_cand;
    logic [3:0]         grant_idx;
    logic               flush;
    logic               do_issue;
    logic               alloc_ok;
    logic [3:0]         alloc_k;
    logic [RS_SIZE-1:0] issued_vec;
    logic [RS_SIZE-1:0] valid_kept;
    logic               cnt_inc;
    logic               cnt_dec;

    assign cand      = valid_q & ready_from_rs;
    assign any_cand  = |cand;
    assign flush     = rst | rollback_flag_from_rob;
    assign do_issue  = rdy & ex_ready_from_ex & ~flush & any_cand;
    assign alloc_ok  = rdy & ~flush & alloc_valid_from_rs & ~alloc_index_from_rs[4];
    assign alloc_k   = alloc_index_from_rs[3:0];

    assign issued_vec = do_issue ? (16'b1 << grant_idx) : '0;
    assign valid_kept = valid_q & ~issued_vec;

    assign issue_valid_to_rs = do_issue;
    assign issue_index_to_rs = do_issue ? {1'b0, grant_idx} : INVALID_RS;
    assign pending_count     = pending_count_q;

`ifdef RS_AGE_ISSUE_EN
    // older_q[i][j] = 1 means slot i was allocated before slot j.
    logic [RS_SIZE-1:0] older_q [RS_SIZE];
    logic [RS_SIZE-1:0] older_d [RS_SIZE];
    logic [RS_SIZE-1:0] has_older;

    always_comb begin
        has_older = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (cand[j] && older_q[j][i]) has_older[i] = 1'b1;
            end
        end
        grant_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i] && !has_older[i]) grant_idx = 4'(i);
        end
    end

    // A (re)allocated slot becomes youngest: everything still tracked is older than it.
    always_comb begin
        older_d = older_q;
        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) older_d[i] = '0;
        end else if (alloc_ok) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                older_d[j][alloc_k] = valid_kept[j] && (4'(j) != alloc_k);
            end
            older_d[alloc_k] = '0;
        end
    end

    // NOTE: the age matrix is reset like ordinary state because flush must clear it anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`else
    always_comb begin
        grant_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) grant_idx = 4'(i);
        end
    end
`endif

    // Count rises only when the alloc makes a slot newly tracked; same-slot issue+alloc nets zero.
    assign cnt_inc = alloc_ok & (~valid_q[alloc_k] | issued_vec[alloc_k]);
    assign cnt_dec = do_issue;

    always_comb begin
        valid_d         = valid_q;
        pending_count_d = pending_count_q;
        if (flush) begin
            valid_d         = '0;
            pending_count_d = '0;
        end else if (rdy) begin
            valid_d = valid_kept;
            if (alloc_ok) valid_d[alloc_k] = 1'b1;
            pending_count_d = pending_count_q + {4'b0, cnt_inc} - {4'b0, cnt_dec};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            pending_count_q <= '0;
        end else begin
            valid_q         <= valid_d;
            pending_count_q <= pending_count_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed self-checking bench for rs_issue_scheduler; expectations follow RS_AGE_ISSUE_EN if defined.
module tb_rs_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        alloc_valid_from_rs = 1'b0;
    logic [4:0]  alloc_index_from_rs = '0;
    logic [15:0] ready_from_rs = '0;
    logic        ex_ready_from_ex = 1'b0;
    logic        rollback_flag_from_rob = 1'b0;
    logic        issue_valid_to_rs;
    logic [4:0]  issue_index_to_rs;
    logic [4:0]  pending_count;

    int  n_total = 0;
    int  n_bad   = 0;
    bit  age;

    rs_issue_scheduler dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .alloc_valid_from_rs    (alloc_valid_from_rs),
        .alloc_index_from_rs    (alloc_index_from_rs),
        .ready_from_rs          (ready_from_rs),
        .ex_ready_from_ex       (ex_ready_from_ex),
        .rollback_flag_from_rob (rollback_flag_from_rob),
        .issue_valid_to_rs      (issue_valid_to_rs),
        .issue_index_to_rs      (issue_index_to_rs),
        .pending_count          (pending_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checking.
    task automatic step(input logic av, input logic [4:0] ai, input logic [15:0] rd,
                        input logic exr, input logic rb, input logic r);
        @(negedge clk);
        rst                    = 1'b0;
        alloc_valid_from_rs    = av;
        alloc_index_from_rs    = ai;
        ready_from_rs          = rd;
        ex_ready_from_ex       = exr;
        rollback_flag_from_rob = rb;
        rdy                    = r;
        #1;
    endtask

    task automatic expect3(input string tag, input logic ev, input logic [4:0] ei, input logic [4:0] ep);
        check({tag, ".valid"}, 32'(issue_valid_to_rs), 32'(ev));
        check({tag, ".index"}, 32'(issue_index_to_rs), 32'(ei));
        check({tag, ".count"}, 32'(pending_count), 32'(ep));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                    = 1'b1;
        rdy                    = 1'b1;
        alloc_valid_from_rs    = 1'b1;
        alloc_index_from_rs    = 5'd3;
        ready_from_rs          = 16'hFFFF;
        ex_ready_from_ex       = 1'b1;
        rollback_flag_from_rob = 1'b0;
        #1;
        check("rst.valid", 32'(issue_valid_to_rs), 32'd0);
        check("rst.index", 32'(issue_index_to_rs), 32'd16);
    endtask

    initial begin
        age = 1'b0;
`ifdef RS_AGE_ISSUE_EN
        age = 1'b1;
`endif
        // Reset, then the three-slot ordering scenario
        do_reset();
        step(1, 5, 16'h0000, 1, 0, 1); expect3("a1", 0, 16, 0);
        step(1, 2, 16'h0000, 1, 0, 1); expect3("a2", 0, 16, 1);
        step(1, 9, 16'h0000, 1, 0, 1); expect3("a3", 0, 16, 2);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("a4", 1, age ? 5'd5 : 5'd2, 3);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("a5", 1, age ? 5'd2 : 5'd5, 2);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("a6", 1, 9, 1);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("a7", 0, 16, 0);

        // EX back-pressure in the second grant cycle
        do_reset();
        step(1, 5, 16'h0000, 1, 0, 1); expect3("b1", 0, 16, 0);
        step(1, 2, 16'h0000, 1, 0, 1); expect3("b2", 0, 16, 1);
        step(1, 9, 16'h0000, 1, 0, 1); expect3("b3", 0, 16, 2);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("b4", 1, age ? 5'd5 : 5'd2, 3);
        step(0, 0, 16'h0224, 0, 0, 1); expect3("b5", 0, 16, 2);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("b6", 1, age ? 5'd2 : 5'd5, 2);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("b7", 1, 9, 1);
        step(0, 0, 16'h0224, 1, 0, 1); expect3("b8", 0, 16, 0);

        // Younger slot issues first when the older one is not ready
        do_reset();
        step(1, 3, 16'h0000, 1, 0, 1); expect3("c1", 0, 16, 0);
        step(1, 1, 16'h0000, 1, 0, 1); expect3("c2", 0, 16, 1);
        step(0, 0, 16'h0002, 1, 0, 1); expect3("c3", 1, 1, 2);
        step(0, 0, 16'h0008, 1, 0, 1); expect3("c4", 1, 3, 1);
        step(0, 0, 16'h0000, 1, 0, 1); expect3("c5", 0, 16, 0);

        // Fill all 16 slots, then roll back with an alloc that must be dropped
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(1, 5'(k), 16'h0000, 1, 0, 1);
            expect3($sformatf("d%0d", k), 0, 16, 5'(k));
        end
        step(1, 3, 16'hFFFF, 1, 1, 1); expect3("d_rb", 0, 16, 16);
        step(0, 0, 16'hFFFF, 1, 0, 1); expect3("d_post", 0, 16, 0);

        // rdy low freezes state and suppresses grants/allocs
        do_reset();
        step(1, 7, 16'h0000, 1, 0, 1); expect3("e1", 0, 16, 0);
        step(1, 4, 16'h0000, 1, 0, 1); expect3("e2", 0, 16, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 12, 16'h0090, 1, 0, 0);
            expect3($sformatf("e_hold%0d", k), 0, 16, 2);
        end
        step(0, 0, 16'h1090, 1, 0, 1); expect3("e3", 1, age ? 5'd7 : 5'd4, 2);
        step(0, 0, 16'h1090, 1, 0, 1); expect3("e4", 1, age ? 5'd4 : 5'd7, 1);
        step(0, 0, 16'h1090, 1, 0, 1); expect3("e5", 0, 16, 0);

        // Re-allocating the slot being issued keeps it tracked and makes it youngest
        do_reset();
        step(1, 6, 16'h0000, 1, 0, 1); expect3("f1", 0, 16, 0);
        step(1, 8, 16'h0000, 1, 0, 1); expect3("f2", 0, 16, 1);
        step(1, 6, 16'h0140, 1, 0, 1); expect3("f3", 1, 6, 2);
        step(0, 0, 16'h0140, 1, 0, 1); expect3("f4", 1, age ? 5'd8 : 5'd6, 2);
        step(0, 0, 16'h0140, 1, 0, 1); expect3("f5", 1, age ? 5'd6 : 5'd8, 1);
        step(0, 0, 16'h0140, 1, 0, 1); expect3("f6", 0, 16, 0);

        // Duplicate alloc into a valid slot and out-of-range indices leave the count alone
        do_reset();
        step(1, 10, 16'h0000, 1, 0, 1); expect3("g1", 0, 16, 0);
        step(1, 10, 16'h0000, 1, 0, 1); expect3("g2", 0, 16, 1);
        step(1, 16, 16'h0000, 1, 0, 1); expect3("g3", 0, 16, 1);
        step(1, 31, 16'h0000, 1, 0, 1); expect3("g4", 0, 16, 1);
        step(0, 0, 16'hFFFF, 1, 0, 1);  expect3("g5", 1, 10, 1);
        step(0, 0, 16'hFFFF, 1, 0, 1);  expect3("g6", 0, 16, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Age-ordered issue selector for the reservation station. It tracks allocation order of the 16 RS slots and, each cycle, grants the oldest slot whose operands are both ready to the ALU/EX stage. It sits between the RS storage array and EX, replacing the fixed lowest-index priority in the RS. It is flushed together with the RS on ROB rollback.

## Interface
- RS_SIZE, 16, number of RS slots; index width 5 bits, index 16 = `INVALID_RS`
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rdy  in  1  global ready; low = hold all state, grant nothing
- alloc_valid_from_rs  in  1  RS inserts an instruction this cycle
- alloc_index_from_rs  in  5  slot being filled (0..15)
- ready_from_rs  in  16  bit i = slot i busy and Q1==Q2==`ZERO_ROB`
- ex_ready_from_ex  in  1  EX can accept an instruction this cycle
- rollback_flag_from_rob  in  1  flush all tracking
- issue_valid_to_rs  out  1  a slot is granted this cycle
- issue_index_to_rs  out  5  granted slot; `INVALID_RS` when issue_valid_to_rs=0
- pending_count  out  5  number of tracked (allocated, not yet issued) slots, 0..16

## Operation
- State: valid[15:0]; age matrix older[i][j] (i≠j), 1 = slot i allocated before slot j; pending_count register.
- Candidate i: valid[i] && ready_from_rs[i].
- Grant: candidate i with no candidate j having older[j][i]=1. Exactly one such i exists whenever ≥1 candidate exists.
- issue_valid_to_rs = rdy && ex_ready_from_ex && !rst && !rollback && (any candidate).
- Allocation of k (on posedge, rdy=1): valid[k]<=1; older[j][k]<=valid[j] for all j≠k (issued-this-cycle j written 0); older[k][j]<=0.
- Issue of g: valid[g]<=0; row/column g need not be cleared (ignored while valid[g]=0).
- pending_count <= pending_count + alloc − issue (both same cycle: unchanged).
- Allocation into a slot currently valid is illegal; if it occurs, alloc wins: valid[k] stays 1, slot k becomes youngest, no count change.
- Alloc and issue of the same index in one cycle: alloc wins (valid stays 1, slot youngest), count unchanged.
- alloc_index ≥ 16 with alloc_valid=1: ignored.
- rollback_flag_from_rob or rst: valid<=0, older<=0, pending_count<=0; no grant that cycle; any alloc that cycle dropped.
- rdy=0: no state change, issue_valid_to_rs=0, issue_index_to_rs=`INVALID_RS`.

## Timing
- Grant is combinational from registered state + ready_from_rs + ex_ready_from_ex; same-cycle with RS read.
- A slot allocated at posedge t is eligible for grant in cycle t+1 onward (if ready).
- Issued slot leaves tracking at the posedge ending the grant cycle.
- Reset values: issue_valid_to_rs=0, issue_index_to_rs=`INVALID_RS`, pending_count=0.
- Rollback priority over rst-free operation identical to rst; rst has priority over rdy.

## Configuration
- RS_AGE_ISSUE_EN defined: oldest-first grant as above.
- Undefined: age matrix not built; grant = lowest-index candidate; valid and pending_count still maintained; all other behaviour unchanged.

## Test plan
- Reset: assert rst 1 cycle -> issue_valid_to_rs=0, issue_index_to_rs=16, pending_count=0.
- Alloc slots 5, 2, 9 in cycles 1,2,3; ready_from_rs=0x0224 from cycle 4, ex_ready=1 -> grants 5, 2, 9 in cycles 4,5,6 (with macro); 2,5,9 without; pending_count 3->0.
- Same as above with ex_ready=0 in cycle 5 -> no grant cycle 5, slot 2 granted cycle 6, slot 9 cycle 7.
- Alloc 3 then 1; only slot 1 ready -> grant 1 despite being younger; slot 3 granted once ready.
- Alloc 0..15 (pending_count=16), rollback in cycle 17 with ready=0xFFFF -> no grant cycle 17, pending_count=0, no grant cycle 18.
- rdy=0 for 3 cycles with ready candidates and alloc_valid=1 -> no grants, pending_count unchanged, order preserved after rdy returns.
